// File: rtl/life_ctrl_sequencer.sv
// Command sequencer for the 16x16 Life array. It loads 16 rows from a host stream,
// issues paced generation steps, and dumps the 16 rows out on a valid/ready stream.
module life_ctrl_sequencer #(
    parameter int STEP_GAP = 4,
    parameter int ROWS     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [15:0] arr_vali,
    output logic [3:0]  arr_vali_selector,
    output logic        arr_write_enb,
    output logic [3:0]  arr_valo_selector,
    input  logic [15:0] arr_valo,
    output logic        arr_step,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_DUMP = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_STEP,
        S_RUN_GAP,
        S_DUMP_SEL,
        S_DUMP_OUT
    } state_t;

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [7:0] GAP_N    = 8'(STEP_GAP);
    localparam logic [7:0] GAP_LAST = 8'(STEP_GAP - 1);

    state_t      state;
    logic [3:0]  row;
    logic [15:0] remaining;
    logic [7:0]  gap_cnt;
    logic        load_fin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            row               <= '0;
            remaining         <= '0;
            gap_cnt           <= '0;
            load_fin          <= 1'b0;
            cmd_ready         <= 1'b0;
            in_ready          <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_last          <= 1'b0;
            arr_vali          <= '0;
            arr_vali_selector <= '0;
            arr_write_enb     <= 1'b0;
            arr_valo_selector <= '0;
            arr_step          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            gen_count         <= '0;
        end else begin
            done          <= 1'b0;
            arr_step      <= 1'b0;
            arr_write_enb <= 1'b0;
            if (abort && state != S_IDLE) begin
                // Any strobe registered last edge has already had its cycle; just drop everything.
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                row       <= '0;
                remaining <= '0;
                gap_cnt   <= '0;
                load_fin  <= 1'b0;
                in_ready  <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cmd_ready <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            row <= '0;
                            case (op_t'(cmd_op))
                                OP_LOAD: begin
                                    state     <= S_LOAD;
                                    in_ready  <= 1'b1;
                                    load_fin  <= 1'b0;
                                    cmd_ready <= 1'b0;
                                    busy      <= 1'b1;
                                end
                                OP_RUN: begin
                                    if (cmd_count != 16'd0) begin
                                        state     <= S_RUN_STEP;
                                        arr_step  <= 1'b1;
                                        gen_count <= gen_count + 16'd1;
                                        remaining <= cmd_count - 16'd1;
                                        cmd_ready <= 1'b0;
                                        busy      <= 1'b1;
                                    end else begin
                                        done <= 1'b1;
                                    end
                                end
                                OP_DUMP: begin
                                    state             <= S_DUMP_SEL;
                                    arr_valo_selector <= '0;
                                    cmd_ready         <= 1'b0;
                                    busy              <= 1'b1;
                                end
                                default: done <= 1'b1;
                            endcase
                        end
                    end

                    S_LOAD: begin
                        if (load_fin) begin
                            state     <= S_IDLE;
                            load_fin  <= 1'b0;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else if (in_valid && in_ready) begin
                            arr_write_enb     <= 1'b1;
                            arr_vali          <= in_data;
                            arr_vali_selector <= row;
                            row               <= row + 4'd1;
                            if (row == LAST_ROW) begin
                                load_fin <= 1'b1;
                                in_ready <= 1'b0;
                            end
                        end
                    end

                    S_RUN_STEP: begin
                        // With a one-cycle gap the final done lands right after the step.
                        if (remaining == 16'd0 && STEP_GAP == 1) begin
                            state     <= S_IDLE;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state   <= S_RUN_GAP;
                            gap_cnt <= 8'd1;
                        end
                    end

                    S_RUN_GAP: begin
                        if (remaining == 16'd0) begin
                            if (gap_cnt == GAP_LAST) begin
                                state     <= S_IDLE;
                                done      <= 1'b1;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                gap_cnt <= gap_cnt + 8'd1;
                            end
                        end else if (gap_cnt == GAP_N) begin
                            state     <= S_RUN_STEP;
                            arr_step  <= 1'b1;
                            gen_count <= gen_count + 16'd1;
                            remaining <= remaining - 16'd1;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end

                    S_DUMP_SEL: begin
                        // Selector was registered on entry, so the array readback is settled now.
                        out_data  <= arr_valo;
                        out_valid <= 1'b1;
                        out_last  <= (row == LAST_ROW);
                        state     <= S_DUMP_OUT;
                    end

                    S_DUMP_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (row == LAST_ROW) begin
                                state     <= S_IDLE;
                                row       <= '0;
                                done      <= 1'b1;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                row               <= row + 4'd1;
                                arr_valo_selector <= row + 4'd1;
                                state             <= S_DUMP_SEL;
                            end
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/life_ctrl_sequencer.md
# life_ctrl_sequencer

Command-driven controller that sequences the 16x16 Life cell array: loads a 16-row pattern from a host stream, issues a programmed number of generation steps at a fixed pacing, and dumps the 16 rows back out on a valid/ready stream. It sits between the host/UART-side logic and the array, and is the only driver of the array's row-write, row-select and step inputs.

## Interface
- STEP_GAP, 4: idle cycles between consecutive step pulses (legal 1..255).
- ROWS, 16: rows per load/dump; fixed at 16, selector width 4.
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high exactly when state is IDLE.
- cmd_op  in  2  00 LOAD, 01 RUN, 10 DUMP, 11 reserved.
- cmd_count  in  16  generations for RUN; ignored otherwise.
- abort  in  1  synchronous; forces return to IDLE, no done.
- in_valid / in_ready  in / out  1 / 1  load-row handshake.
- in_data  in  16  load row data.
- out_valid / out_ready  out / in  1 / 1  dump-row handshake.
- out_data  out  16  dumped row; out_last  out  1  high with row 15.
- arr_vali  out  16  row data to array; arr_vali_selector  out  4  write row index.
- arr_write_enb  out  1  one-cycle row write strobe.
- arr_valo_selector  out  4  read row index; arr_valo  in  16  array row readback.
- arr_step  out  1  one-cycle generation strobe.
- busy  out  1  state != IDLE; done  out  1  one-cycle completion pulse.
- gen_count  out  16  total steps issued since reset, wraps 0xFFFF->0x0000.

## Operation
- States: IDLE, LOAD, RUN_STEP, RUN_GAP, DUMP_SEL, DUMP_OUT.
- IDLE: cmd_ready=1; handshake (cmd_valid&cmd_ready) latches op/count. LOAD->LOAD, RUN with count>0 ->RUN_STEP, RUN count=0 ->IDLE with done, DUMP->DUMP_SEL, op 11 accepted and dropped with done.
- LOAD: in_ready=1. Each in handshake: next cycle arr_write_enb=1, arr_vali=in_data, arr_vali_selector=row; row increments mod 16. After row 15 strobe, next cycle ->IDLE with done.
- RUN_STEP: arr_step=1 for one cycle, gen_count+1, remaining-1; ->RUN_GAP. RUN_GAP: count STEP_GAP cycles; then remaining>0 ->RUN_STEP, else ->IDLE with done.
- DUMP_SEL: drive arr_valo_selector=row (registered), ->DUMP_OUT. DUMP_OUT: out_data=arr_valo captured on entry, out_valid=1 held stable until out_ready; on handshake row+1, ->DUMP_SEL, or after row 15 ->IDLE with done.
- abort in any non-IDLE state: next cycle state=IDLE, row/remaining cleared, all strobes and valids low, no done; in-flight write strobe already registered still completes. abort in IDLE ignored.
- Only one of arr_write_enb/arr_step ever high in a cycle; both low in IDLE.

## Timing
- Reset values: cmd_ready=0 while reset low, 1 first cycle after release; every other output 0; arr selectors 0; gen_count 0.
- Command accepted at edge N: RUN first arr_step high in cycle N+1; step pulses exactly STEP_GAP+1 cycles apart; done high STEP_GAP cycles after the last step pulse, coincident with cmd_ready=1.
- LOAD: write strobe 1 cycle after each row handshake; done 1 cycle after 16th strobe; minimum 17 cycles for 16 back-to-back rows after command.
- DUMP: arr_valo sampled one cycle after selector update; max one row per 2 cycles; out_data/out_last must not change while out_valid&!out_ready.
- RUN count 0: done in cycle N+1, no step, gen_count unchanged.
- Reset asserted mid-operation: immediate clear, no done, no strobes.

## Test plan
- Reset release -> all outputs 0, cmd_ready=1 next cycle, gen_count=0.
- LOAD with rows 0x0001..0x8000 (walking one), in_valid always high -> 16 write strobes, selector 0..15, arr_vali matching, done 17 cycles after command.
- RUN count=3, STEP_GAP=4 -> arr_step in cycles N+1, N+6, N+11; done at N+15; gen_count=3.
- DUMP with out_ready toggling 1/0, array model returning row^0xA5A5 -> 16 rows in order, data stable while stalled, out_last only on row 15, done after last handshake.
- RUN count=0xFFFF, abort after 10 steps -> IDLE next cycle, no done, gen_count=10; then RUN count=0 -> done in 1 cycle, no step.
- gen_count preset by 0xFFFE steps then RUN count=3 -> gen_count wraps to 0x0001.
